wb_stage_skid_reg: RTL and testbench

- Parametrised successor to the MEM->WB pipeline register.
- Carries the full writeback payload: PC, WB_EN, MEM_R_EN, ALU result, memory data and destination register.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, a synchronous flush, and a qualified writeback-value mux.
- Sits between the MEM stage and the register file / forwarding unit.

---
 rtl/wb_stage_skid_reg.sv | 138 +++++++++++++
 tb/tb_wb_stage_skid_reg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_skid_reg.sv
// MEM->WB pipeline register: valid/ready handshake, 2-entry skid buffer, flush, writeback mux.
// Optional performance counters are enabled with `define WB_STAGE_PERF_EN.
module wb_stage_skid_reg #(
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned ADDRESS_LEN  = 32,
  parameter int unsigned REG_ADDR_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_LEN-1:0]  PC_in,
  input  logic                    WB_EN_in,
  input  logic                    MEM_R_EN_in,
  input  logic [DATA_LEN-1:0]     ALU_result_in,
  input  logic [DATA_LEN-1:0]     mem_data_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_LEN-1:0]  PC,
  output logic                    WB_EN,
  output logic [REG_ADDR_LEN-1:0] dest,
  output logic [DATA_LEN-1:0]     wb_value,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_retire_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [ADDRESS_LEN-1:0]  pc;
    logic                    wb_en;
    logic                    mem_r_en;
    logic [DATA_LEN-1:0]     alu_result;
    logic [DATA_LEN-1:0]     mem_data;
    logic [REG_ADDR_LEN-1:0] dest;
  } payload_t;

  payload_t in_pl;
  payload_t main_q, main_n;
  payload_t skid_q, skid_n;
  logic     main_valid, main_valid_n;
  logic     skid_valid, skid_valid_n;
  logic     accept;
  logic     fire;
  logic     load_main;

  always_comb begin
    in_pl.pc         = PC_in;
    in_pl.wb_en      = WB_EN_in;
    in_pl.mem_r_en   = MEM_R_EN_in;
    in_pl.alu_result = ALU_result_in;
    in_pl.mem_data   = mem_data_in;
    in_pl.dest       = dest_in;
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid & ~skid_valid;
  assign fire      = main_valid & out_ready;
  assign load_main = ~main_valid | out_ready;

  // Next-state for both entries; payloads only move on a transfer, never cleared on consumption.
  always_comb begin
    main_n       = main_q;
    skid_n       = skid_q;
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (load_main) begin
      if (skid_valid) begin
        main_n       = skid_q;
        main_valid_n = 1'b1;
        skid_valid_n = 1'b0;
      end else begin
        main_valid_n = accept;
        if (accept) begin
          main_n = in_pl;
        end
      end
    end else if (accept) begin
      skid_n       = in_pl;
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
    end
  end

  // WB_EN is qualified so a stale payload can never write the register file.
  assign PC       = main_q.pc;
  assign dest     = main_q.dest;
  assign WB_EN    = main_valid & main_q.wb_en;
  assign wb_value = main_q.mem_r_en ? main_q.mem_data : main_q.alu_result;

`ifdef WB_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] retire_cnt_q;

  // Stall count saturates; retire count wraps. Only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (fire) begin
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_retire_cnt = retire_cnt_q;
`else
  logic unused_fire;
  assign unused_fire     = fire;
  assign perf_stall_cnt  = '0;
  assign perf_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// Directed scoreboard bench for wb_stage_skid_reg; expectations come from a queue model.
module tb_wb_stage_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] PC_in;
  logic        WB_EN_in;
  logic        MEM_R_EN_in;
  logic [31:0] ALU_result_in;
  logic [31:0] mem_data_in;
  logic [3:0]  dest_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] PC;
  logic        WB_EN;
  logic [3:0]  dest;
  logic [31:0] wb_value;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_retire_cnt;

  wb_stage_skid_reg dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .PC_in          (PC_in),
    .WB_EN_in       (WB_EN_in),
    .MEM_R_EN_in    (MEM_R_EN_in),
    .ALU_result_in  (ALU_result_in),
    .mem_data_in    (mem_data_in),
    .dest_in        (dest_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .PC             (PC),
    .WB_EN          (WB_EN),
    .dest           (dest),
    .wb_value       (wb_value),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_retire_cnt(perf_retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        wb_en;
    logic [3:0]  dest;
    logic [31:0] wbv;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_retire = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model at the negedge, then advance the model for the coming edge.
  task automatic tick();
    bit ov;
    bit acc;
    @(negedge clk);
    ov = (q.size() > 0);
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("wb_en", 32'(WB_EN), ov ? 32'(q[0].wb_en) : 32'd0);
      if (ov) begin
        chk("pc", PC, q[0].pc);
        chk("dest", 32'(dest), 32'(q[0].dest));
        chk("wb_value", wb_value, q[0].wbv);
      end
`ifdef WB_STAGE_PERF_EN
      chk("perf_stall", perf_stall_cnt, exp_stall);
      chk("perf_retire", perf_retire_cnt, exp_retire);
`else
      chk("perf_stall_tied", perf_stall_cnt, 32'd0);
      chk("perf_retire_tied", perf_retire_cnt, 32'd0);
`endif
    end
    if (rst) begin
      q.delete();
      exp_stall  = '0;
      exp_retire = '0;
    end else begin
      if (ov && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
      if (flush) begin
        q.delete();
      end else begin
        acc = in_valid && (q.size() < 2);
        if (ov && out_ready) begin
          cur = q.pop_front();
          exp_retire++;
        end
        if (acc) begin
          cur.pc    = PC_in;
          cur.wb_en = WB_EN_in;
          cur.dest  = dest_in;
          cur.wbv   = MEM_R_EN_in ? mem_data_in : ALU_result_in;
          q.push_back(cur);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic wb_en, input logic mr,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] d);
    in_valid      = 1'b1;
    PC_in         = pc;
    WB_EN_in      = wb_en;
    MEM_R_EN_in   = mr;
    ALU_result_in = alu;
    mem_data_in   = mem;
    dest_in       = d;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    send(32'h99, 1'b1, 1'b0, 32'h77, 32'h66, 4'd9);
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset held with in_valid=1: nothing accepted, all outputs zero.
    repeat (2) begin
      tick();
      chk("rst_pc", PC, 32'd0);
      chk("rst_wbv", wb_value, 32'd0);
      chk("rst_dest", 32'(dest), 32'd0);
    end
    rst = 1'b0;
    idle();
    tick();

    // Streaming with out_ready high.
    send(32'h10, 1'b1, 1'b0, 32'hA, 32'h0, 4'd1); tick();
    send(32'h14, 1'b1, 1'b0, 32'hB, 32'h0, 4'd2); tick();
    send(32'h18, 1'b1, 1'b0, 32'hC, 32'h0, 4'd3); tick();
    idle(); tick(); tick();

    // Writeback mux select.
    send(32'h1C, 1'b1, 1'b1, 32'h1234, 32'hDEAD_BEEF, 4'd4); tick();
    send(32'h1E, 1'b0, 1'b0, 32'h1234, 32'hDEAD_BEEF, 4'd5); tick();
    idle(); tick(); tick();

    // Back-pressure fills both entries, then drains in order.
    out_ready = 1'b0;
    send(32'h20, 1'b1, 1'b0, 32'h20, 32'h0, 4'd6); tick();
    send(32'h24, 1'b1, 1'b0, 32'h24, 32'h0, 4'd7); tick();
    send(32'h28, 1'b1, 1'b0, 32'h28, 32'h0, 4'd8); tick();
    idle(); tick();
    chk("bp_pc_hold", PC, 32'h20);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Flush with both entries full and a simultaneous input.
    out_ready = 1'b0;
    send(32'h40, 1'b1, 1'b0, 32'h40, 32'h0, 4'd10); tick();
    send(32'h44, 1'b1, 1'b0, 32'h44, 32'h0, 4'd11); tick();
    flush = 1'b1;
    send(32'h30, 1'b1, 1'b0, 32'h30, 32'h0, 4'd12); tick();
    flush = 1'b0;
    idle(); tick();
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_wb_en", 32'(WB_EN), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick(); tick();
    send(32'h34, 1'b1, 1'b1, 32'h0, 32'h3434, 4'd13); tick();
    idle(); tick(); tick();

    // Perf counters from a clean reset: 5 stalls, 3 retirements.
    rst = 1'b1; tick();
    rst = 1'b0;
    out_ready = 1'b0;
    send(32'h50, 1'b1, 1'b0, 32'h50, 32'h0, 4'd1); tick();
    send(32'h54, 1'b1, 1'b0, 32'h54, 32'h0, 4'd2); tick();
    idle(); repeat (4) tick();
    out_ready = 1'b1;
    tick(); tick();
    send(32'h58, 1'b1, 1'b0, 32'h58, 32'h0, 4'd3); tick();
    idle(); tick(); tick();
`ifdef WB_STAGE_PERF_EN
    chk("perf_stall_final", perf_stall_cnt, 32'd5);
    chk("perf_retire_final", perf_retire_cnt, 32'd3);
`else
    chk("perf_stall_final", perf_stall_cnt, 32'd0);
    chk("perf_retire_final", perf_retire_cnt, 32'd0);
`endif
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
